smu_bitstream_serializer: RTL and testbench
===========================================

// Module: smu_bitstream_serializer
// PURPOSE
//   Transmit side of the SMU configuration bitstream link. Captures a CFG_SIZE-bit parallel
//   config word and shifts it out one bit per clock on SerialOut/StreamValid. These outputs drive
//   the SerialIn/StreamValid inputs of the SMU bitstream deserializer. Sits between the config
//   source (CSR/loader) and the SMU patch fabric.
// PARAMETERS
//   CFG_SIZE   100   payload bits per config word (>= 2); must equal the deserializer's CFG_SIZE
// PORTS
//   clk          in   1          clock
//   rst          in   1          reset, asynchronous, active-high
//   CfgIn        in   CFG_SIZE   parallel config word; sampled only on an accepted load
//   CfgLoad      in   1          load request; accepted when CfgLoad && CfgReady at posedge clk
//   CfgReady     out  1          high in IDLE: block can accept a new word
//   StreamStall  in   1          back-pressure; while high no bit is emitted and state holds
//   SerialOut    out  1          current stream bit (MSB of shift register)
//   StreamValid  out  1          SerialOut carries a valid bit this cycle
//   CfgSent      out  1          sticky: last word fully transmitted; cleared by next accepted load
// BEHAVIOUR
//   - Reset (async): state=IDLE, shift reg=0, count=0; CfgReady=1, StreamValid=0, SerialOut=0, CfgSent=0.
//     Reset mid-transfer aborts it; StreamValid drops immediately (combinational from state).
//   - FSM: IDLE -> SHIFT on accepted load; SHIFT -> IDLE after final bit (-> PARITY if SMU_SER_PARITY_EN).
//   - IDLE: CfgReady=1. Accepted load: shift reg<=CfgIn, count<=0, CfgSent<=0, state<=SHIFT.
//   - SHIFT: StreamValid = !StreamStall; SerialOut = shift[CFG_SIZE-1] (MSB first, so the
//     deserializer's left-shift lands bit CFG_SIZE-1 at ParallelOut MSB).
//     Each cycle with StreamValid: shift reg <<= 1 (LSB fill 0), count++. When valid && count==CFG_SIZE-1:
//     leave SHIFT, set CfgSent (no parity) next edge.
//   - Stall: StreamValid=0; SerialOut, shift reg and count hold. Stall in IDLE has no effect.
//   - CfgLoad while not IDLE is ignored (no capture, no error). CfgIn is don't-care outside accept.
//   - Timing (no stall): load accepted at edge 0; bits valid cycles 1..CFG_SIZE; CfgReady and CfgSent
//     high from cycle CFG_SIZE+1. A load in that cycle is accepted; CfgSent clears the next cycle.
//   - Count width $clog2(CFG_SIZE+1); it never wraps (bounded by CFG_SIZE-1 in SHIFT).
// CONFIGURATION
//   SMU_SER_PARITY_EN defined: PARITY state after the payload emits one even-parity bit
//     (XOR of the captured word, latched at load), also stallable; CfgSent set after it.
//     Link total = CFG_SIZE+1 bits; the receiver must be sized accordingly.
//   Not defined: no PARITY state and no parity register; exactly CFG_SIZE bits per word.
// STRUCTURE
//   - smu_cfg_pkg: typedef enum logic [1:0] {SER_IDLE, SER_SHIFT, SER_PARITY} smu_ser_state_t;
//     count-width helper function shared with the deserializer.
//   - Single module; no sub-module: shift reg, counter and 3-state FSM are too small to split.
// TESTING (CFG_SIZE=8 bench; loopback into deserializer with CFG_SIZE=8)
//   1. Load 8'hA5, no stall -> SerialOut 1,0,1,0,0,1,0,1 valid cycles 1..8; CfgSent=1 cycle 9;
//      deserializer ParallelOut=8'hA5, CfgDone=1.
//   2. Load 8'hA5, StreamStall high cycles 3-4 -> StreamValid=0 those cycles; bit order unchanged;
//      CfgSent at cycle 11.
//   3. Load 8'hA5, pulse CfgLoad with CfgIn=8'hFF at cycle 4 -> ignored; stream remains 8'hA5.
//   4. Load 8'hA5, assert rst mid-cycle after bit 4 -> StreamValid=0 at once, CfgSent=0;
//      after release CfgReady=1; load 8'h3C -> 0,0,1,1,1,1,0,0 sent cleanly.
//   5. SMU_SER_PARITY_EN: load 8'h07 -> 9th valid bit=1; load 8'h03 -> 9th bit=0; CfgSent cycle 10.
//   6. CfgLoad held high, CfgIn 8'h5A then 8'hC3 -> second word accepted in cycle 9 (CfgSent=1),
//      CfgSent=0 cycle 10, second stream starts cycle 10 with no gap.

Source files
------------

// File: rtl/smu_cfg_pkg.sv
// Shared types and helpers for the SMU configuration bitstream link
// (serializer and deserializer).
package smu_cfg_pkg;

    typedef enum logic [1:0] {
        SER_IDLE   = 2'd0,
        SER_SHIFT  = 2'd1,
        SER_PARITY = 2'd2
    } smu_ser_state_t;

    // Bit counter width for a word of n payload bits; holds 0..n.
    function automatic int unsigned smu_cnt_width(input int unsigned n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/smu_bitstream_serializer.sv
// Transmit side of the SMU config bitstream link: captures a parallel word and shifts it out MSB first.
// Optional trailing even-parity bit when SMU_SER_PARITY_EN is defined.
module smu_bitstream_serializer
    import smu_cfg_pkg::*;
#(
    parameter int unsigned CFG_SIZE = 100
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CFG_SIZE-1:0] CfgIn,
    input  logic                CfgLoad,
    output logic                CfgReady,
    input  logic                StreamStall,
    output logic                SerialOut,
    output logic                StreamValid,
    output logic                CfgSent
);

    localparam int unsigned     CNT_W    = smu_cnt_width(CFG_SIZE);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(CFG_SIZE - 1);

    smu_ser_state_t      state_q, state_d;
    logic [CFG_SIZE-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                sent_q,  sent_d;
`ifdef SMU_SER_PARITY_EN
    logic                parity_q, parity_d;
`endif

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= SER_IDLE;
            shift_q  <= '0;
            count_q  <= '0;
            sent_q   <= 1'b0;
`ifdef SMU_SER_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            count_q  <= count_d;
            sent_q   <= sent_d;
`ifdef SMU_SER_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    // Next-state and handshake; StreamValid follows state so a reset drops it at once.
    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        count_d     = count_q;
        sent_d      = sent_q;
`ifdef SMU_SER_PARITY_EN
        parity_d    = parity_q;
`endif
        CfgReady    = 1'b0;
        StreamValid = 1'b0;
        SerialOut   = shift_q[CFG_SIZE-1];

        case (state_q)
            SER_IDLE: begin
                CfgReady = 1'b1;
                if (CfgLoad) begin
                    shift_d  = CfgIn;
                    count_d  = '0;
                    sent_d   = 1'b0;
                    state_d  = SER_SHIFT;
`ifdef SMU_SER_PARITY_EN
                    parity_d = ^CfgIn;
`endif
                end
            end

            SER_SHIFT: begin
                StreamValid = !StreamStall;
                if (!StreamStall) begin
                    shift_d = {shift_q[CFG_SIZE-2:0], 1'b0};
                    count_d = count_q + CNT_W'(1);
                    if (count_q == LAST_IDX) begin
`ifdef SMU_SER_PARITY_EN
                        state_d = SER_PARITY;
`else
                        state_d = SER_IDLE;
                        sent_d  = 1'b1;
`endif
                    end
                end
            end

`ifdef SMU_SER_PARITY_EN
            SER_PARITY: begin
                SerialOut   = parity_q;
                StreamValid = !StreamStall;
                if (!StreamStall) begin
                    state_d = SER_IDLE;
                    sent_d  = 1'b1;
                end
            end
`endif

            default: begin
                state_d = SER_IDLE;
            end
        endcase
    end

    assign CfgSent = sent_q;

endmodule

// File: tb/tb_smu_bitstream_serializer.sv
// Directed bench for smu_bitstream_serializer at CFG_SIZE=8; honours SMU_SER_PARITY_EN.
module tb_smu_bitstream_serializer;

    localparam int unsigned N = 8;
`ifdef SMU_SER_PARITY_EN
    localparam int LINK = N + 1;
`else
    localparam int LINK = N;
`endif

    logic         clk;
    logic         rst;
    logic [N-1:0] CfgIn;
    logic         CfgLoad;
    logic         CfgReady;
    logic         StreamStall;
    logic         SerialOut;
    logic         StreamValid;
    logic         CfgSent;

    int errors;
    int checks;

    smu_bitstream_serializer #(.CFG_SIZE(N)) dut (
        .clk         (clk),
        .rst         (rst),
        .CfgIn       (CfgIn),
        .CfgLoad     (CfgLoad),
        .CfgReady    (CfgReady),
        .StreamStall (StreamStall),
        .SerialOut   (SerialOut),
        .StreamValid (StreamValid),
        .CfgSent     (CfgSent)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected link bit i for word w: payload MSB first, then even parity.
    function automatic logic exp_bit(input logic [7:0] w, input int i);
        if (i < 8) return w[7-i];
        return ^w;
    endfunction

    task automatic test_reset();
        rst = 1'b1; CfgLoad = 1'b0; CfgIn = '0; StreamStall = 1'b0;
        #1;
        checks++;
        if (CfgReady !== 1'b1 || StreamValid !== 1'b0 || SerialOut !== 1'b0 || CfgSent !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: ready=%b valid=%b out=%b sent=%b, want 1 0 0 0",
                     CfgReady, StreamValid, SerialOut, CfgSent);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        StreamStall = 1'b1;
        @(negedge clk); #1;
        checks++;
        if (CfgReady !== 1'b1 || StreamValid !== 1'b0) begin
            errors++;
            $display("FAIL idle_stall: ready=%b valid=%b, want 1 0", CfgReady, StreamValid);
        end
        StreamStall = 1'b0;
    endtask

    task automatic test_basic();
        logic [7:0] rx;
        rx = '0;
        @(negedge clk); CfgIn = 8'hA5; CfgLoad = 1'b1;
        for (int c = 1; c <= LINK; c++) begin
            @(negedge clk); CfgLoad = 1'b0; CfgIn = '0; #1;
            checks++;
            if (StreamValid !== 1'b1 || SerialOut !== exp_bit(8'hA5, c - 1)) begin
                errors++;
                $display("FAIL basic_bit%0d: valid=%b out=%b, want valid=1 out=%b",
                         c, StreamValid, SerialOut, exp_bit(8'hA5, c - 1));
            end
            if (c <= 8) rx = {rx[6:0], SerialOut};
            if (c == 1) begin
                checks++;
                if (CfgReady !== 1'b0 || CfgSent !== 1'b0) begin
                    errors++;
                    $display("FAIL basic_busy: ready=%b sent=%b, want 0 0", CfgReady, CfgSent);
                end
            end
        end
        @(negedge clk); #1;
        checks++;
        if (CfgSent !== 1'b1 || CfgReady !== 1'b1 || StreamValid !== 1'b0) begin
            errors++;
            $display("FAIL basic_done: sent=%b ready=%b valid=%b, want 1 1 0",
                     CfgSent, CfgReady, StreamValid);
        end
        checks++;
        if (rx !== 8'hA5) begin
            errors++;
            $display("FAIL basic_word: got %h, want a5", rx);
        end
    endtask

    task automatic test_stall();
        int k;
        k = 0;
        @(negedge clk); CfgIn = 8'hA5; CfgLoad = 1'b1;
        for (int c = 1; c <= LINK + 2; c++) begin
            @(negedge clk); CfgLoad = 1'b0;
            StreamStall = (c == 3 || c == 4);
            #1;
            checks++;
            if (StreamStall) begin
                if (StreamValid !== 1'b0 || SerialOut !== exp_bit(8'hA5, k)) begin
                    errors++;
                    $display("FAIL stall_cycle%0d: valid=%b out=%b, want valid=0 out=%b",
                             c, StreamValid, SerialOut, exp_bit(8'hA5, k));
                end
            end else begin
                if (StreamValid !== 1'b1 || SerialOut !== exp_bit(8'hA5, k)) begin
                    errors++;
                    $display("FAIL stall_bit%0d: valid=%b out=%b, want valid=1 out=%b",
                             k, StreamValid, SerialOut, exp_bit(8'hA5, k));
                end
                k++;
            end
        end
        checks++;
        if (CfgSent !== 1'b0) begin
            errors++;
            $display("FAIL stall_sent_early: sent=%b, want 0", CfgSent);
        end
        @(negedge clk); StreamStall = 1'b0; #1;
        checks++;
        if (CfgSent !== 1'b1 || CfgReady !== 1'b1) begin
            errors++;
            $display("FAIL stall_done: sent=%b ready=%b, want 1 1", CfgSent, CfgReady);
        end
    endtask

    task automatic test_ignore_load();
        logic [7:0] rx;
        rx = '0;
        @(negedge clk); CfgIn = 8'hA5; CfgLoad = 1'b1;
        for (int c = 1; c <= LINK; c++) begin
            @(negedge clk);
            CfgLoad = (c == 4);
            CfgIn   = (c == 4) ? 8'hFF : 8'h00;
            #1;
            checks++;
            if (StreamValid !== 1'b1 || SerialOut !== exp_bit(8'hA5, c - 1)) begin
                errors++;
                $display("FAIL ignore_bit%0d: valid=%b out=%b, want valid=1 out=%b",
                         c, StreamValid, SerialOut, exp_bit(8'hA5, c - 1));
            end
            if (c <= 8) rx = {rx[6:0], SerialOut};
            if (c == 4) begin
                checks++;
                if (CfgReady !== 1'b0) begin
                    errors++;
                    $display("FAIL ignore_ready: ready=%b, want 0", CfgReady);
                end
            end
        end
        @(negedge clk); CfgLoad = 1'b0; #1;
        checks++;
        if (rx !== 8'hA5 || CfgSent !== 1'b1) begin
            errors++;
            $display("FAIL ignore_word: got %h sent=%b, want a5 sent=1", rx, CfgSent);
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] rx;
        @(negedge clk); CfgIn = 8'hA5; CfgLoad = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk); CfgLoad = 1'b0; #1;
            checks++;
            if (StreamValid !== 1'b1 || SerialOut !== exp_bit(8'hA5, c - 1)) begin
                errors++;
                $display("FAIL rstmid_bit%0d: valid=%b out=%b, want valid=1 out=%b",
                         c, StreamValid, SerialOut, exp_bit(8'hA5, c - 1));
            end
        end
        #1; rst = 1'b1; #1;
        checks++;
        if (StreamValid !== 1'b0 || CfgSent !== 1'b0 || CfgReady !== 1'b1 || SerialOut !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_abort: valid=%b sent=%b ready=%b out=%b, want 0 0 1 0",
                     StreamValid, CfgSent, CfgReady, SerialOut);
        end
        @(negedge clk); rst = 1'b0; #1;
        checks++;
        if (CfgReady !== 1'b1 || StreamValid !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_release: ready=%b valid=%b, want 1 0", CfgReady, StreamValid);
        end
        rx = '0;
        @(negedge clk); CfgIn = 8'h3C; CfgLoad = 1'b1;
        for (int c = 1; c <= LINK; c++) begin
            @(negedge clk); CfgLoad = 1'b0; #1;
            checks++;
            if (StreamValid !== 1'b1 || SerialOut !== exp_bit(8'h3C, c - 1)) begin
                errors++;
                $display("FAIL rstmid_3c_bit%0d: valid=%b out=%b, want valid=1 out=%b",
                         c, StreamValid, SerialOut, exp_bit(8'h3C, c - 1));
            end
            if (c <= 8) rx = {rx[6:0], SerialOut};
        end
        @(negedge clk); #1;
        checks++;
        if (rx !== 8'h3C || CfgSent !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_3c_word: got %h sent=%b, want 3c sent=1", rx, CfgSent);
        end
    endtask

`ifdef SMU_SER_PARITY_EN
    task automatic test_parity();
        logic [7:0] words [2];
        logic       pbits [2];
        words[0] = 8'h07; pbits[0] = 1'b1;
        words[1] = 8'h03; pbits[1] = 1'b0;
        for (int w = 0; w < 2; w++) begin
            @(negedge clk); CfgIn = words[w]; CfgLoad = 1'b1;
            for (int c = 1; c <= 9; c++) begin
                @(negedge clk); CfgLoad = 1'b0; #1;
                if (c == 9) begin
                    checks++;
                    if (StreamValid !== 1'b1 || SerialOut !== pbits[w] || CfgSent !== 1'b0) begin
                        errors++;
                        $display("FAIL parity_bit_%h: valid=%b out=%b sent=%b, want 1 %b 0",
                                 words[w], StreamValid, SerialOut, CfgSent, pbits[w]);
                    end
                end
            end
            @(negedge clk); #1;
            checks++;
            if (CfgSent !== 1'b1 || StreamValid !== 1'b0) begin
                errors++;
                $display("FAIL parity_done_%h: sent=%b valid=%b, want 1 0",
                         words[w], CfgSent, StreamValid);
            end
        end
    endtask
`endif

    task automatic test_back_to_back();
        logic [7:0] rx;
        rx = '0;
        @(negedge clk); CfgIn = 8'h5A; CfgLoad = 1'b1;
        for (int c = 1; c <= LINK; c++) begin
            @(negedge clk); CfgIn = 8'hC3; #1;
            checks++;
            if (StreamValid !== 1'b1 || SerialOut !== exp_bit(8'h5A, c - 1)) begin
                errors++;
                $display("FAIL b2b_first_bit%0d: valid=%b out=%b, want valid=1 out=%b",
                         c, StreamValid, SerialOut, exp_bit(8'h5A, c - 1));
            end
        end
        @(negedge clk); #1;
        checks++;
        if (CfgSent !== 1'b1 || CfgReady !== 1'b1 || StreamValid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_gap: sent=%b ready=%b valid=%b, want 1 1 0",
                     CfgSent, CfgReady, StreamValid);
        end
        for (int c = 1; c <= LINK; c++) begin
            @(negedge clk); CfgLoad = 1'b0; #1;
            checks++;
            if (StreamValid !== 1'b1 || SerialOut !== exp_bit(8'hC3, c - 1)) begin
                errors++;
                $display("FAIL b2b_second_bit%0d: valid=%b out=%b, want valid=1 out=%b",
                         c, StreamValid, SerialOut, exp_bit(8'hC3, c - 1));
            end
            if (c <= 8) rx = {rx[6:0], SerialOut};
            if (c == 1) begin
                checks++;
                if (CfgSent !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b_sent_clear: sent=%b, want 0", CfgSent);
                end
            end
        end
        @(negedge clk); #1;
        checks++;
        if (rx !== 8'hC3 || CfgSent !== 1'b1) begin
            errors++;
            $display("FAIL b2b_word: got %h sent=%b, want c3 sent=1", rx, CfgSent);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_basic();
        test_stall();
        test_ignore_load();
        test_reset_mid();
`ifdef SMU_SER_PARITY_EN
        test_parity();
`endif
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
